// File: rtl/code2_pipe_pkg.sv
// Shared widths, instruction field positions and the decoded-field record
// for the code2 decode stage.
package code2_pipe_pkg;

   localparam int unsigned I_W = 24;
   localparam int unsigned P_W = 16;
   localparam int unsigned D_W = 32;
   localparam int unsigned R_W = 5;
   localparam int unsigned F_W = 3;

   localparam int unsigned OP_BIT     = 0;
   localparam int unsigned FUNCT3_LSB = 1;
   localparam int unsigned RD_LSB     = 4;
   localparam int unsigned RS_LSB     = 9;
   localparam int unsigned RT_LSB     = 14;

   typedef struct packed {
      logic           op;
      logic [F_W-1:0] funct3;
      logic [R_W-1:0] rd;
      logic [R_W-1:0] rs_idx;
      logic [R_W-1:0] rt_idx;
   } dec_fields_t;

   function automatic dec_fields_t decode_fields(input logic [I_W-1:0] instr);
      dec_fields_t f;
      f.op     = instr[OP_BIT];
      f.funct3 = instr[FUNCT3_LSB +: F_W];
      f.rd     = instr[RD_LSB +: R_W];
      f.rs_idx = instr[RS_LSB +: R_W];
      f.rt_idx = instr[RT_LSB +: R_W];
      return f;
   endfunction

endpackage

// File: rtl/code2_pipe_reg_bank.sv
// 2-read/1-write register file: synchronous clear, hardwired zero register,
// and same-cycle write-to-read bypass on both read ports.
module reg_bank
   import code2_pipe_pkg::*;
#(
   parameter int unsigned D = D_W,
   parameter int unsigned R = R_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we3,
   input  logic [R-1:0] wa3,
   input  logic [D-1:0] wd3,
   input  logic [R-1:0] ra1,
   input  logic [R-1:0] ra2,
   output logic [D-1:0] rd1,
   output logic [D-1:0] rd2
);

   localparam int unsigned N = 2 ** R;

   logic [D-1:0] regs_q [N];
   logic [D-1:0] regs_d [N];
   logic         wr_en;

   assign wr_en = we3 && (wa3 != '0);

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[wa3] = wd3;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < N; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Bypass lets the decode stage see a value being written back this same cycle.
   always_comb begin
      rd1 = regs_q[ra1];
      rd2 = regs_q[ra2];
      if (wr_en && (wa3 == ra1)) rd1 = wd3;
      if (wr_en && (wa3 == ra2)) rd2 = wd3;
      if (ra1 == '0) rd1 = '0;
      if (ra2 == '0) rd2 = '0;
   end

endmodule

// File: rtl/code2_pipe.sv
// Instruction-decode stage: field extraction, operand read and the
// decode/execute pipeline register.
module code2_pipe
   import code2_pipe_pkg::*;
#(
   parameter int unsigned I = I_W,
   parameter int unsigned P = P_W,
   parameter int unsigned D = D_W,
   parameter int unsigned R = R_W,
   parameter int unsigned F = F_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we3,
   input  logic [P-1:0] next_pc_i,
   input  logic [I-1:0] instr_i,
   input  logic [R-1:0] wa3,
   input  logic [D-1:0] wd3,
   output logic         op_o,
   output logic [F-1:0] funct3_o,
   output logic [R-1:0] rd_o,
   output logic [D-1:0] rs_o,
   output logic [D-1:0] rt_o,
   output logic [P-1:0] next_pc_o
);

   dec_fields_t  fields;
   logic [D-1:0] rs_data;
   logic [D-1:0] rt_data;
   logic         unused_rsvd;

   assign fields      = decode_fields(instr_i);
   assign unused_rsvd = ^instr_i[I-1:RT_LSB+R];

   reg_bank #(
      .D (D),
      .R (R)
   ) u_reg_bank (
      .clk (clk),
      .rst (rst),
      .we3 (we3),
      .wa3 (wa3),
      .wd3 (wd3),
      .ra1 (fields.rs_idx),
      .ra2 (fields.rt_idx),
      .rd1 (rs_data),
      .rd2 (rt_data)
   );

   logic         op_d,     op_q;
   logic [F-1:0] funct3_d, funct3_q;
   logic [R-1:0] rd_d,     rd_q;
   logic [D-1:0] rs_d,     rs_q;
   logic [D-1:0] rt_d,     rt_q;
   logic [P-1:0] npc_d,    npc_q;

   always_comb begin
      op_d     = fields.op;
      funct3_d = fields.funct3;
      rd_d     = fields.rd;
      rs_d     = rs_data;
      rt_d     = rt_data;
      npc_d    = next_pc_i;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         op_q     <= 1'b0;
         funct3_q <= '0;
         rd_q     <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         npc_q    <= '0;
      end else begin
         op_q     <= op_d;
         funct3_q <= funct3_d;
         rd_q     <= rd_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         npc_q    <= npc_d;
      end
   end

   assign op_o      = op_q;
   assign funct3_o  = funct3_q;
   assign rd_o      = rd_q;
   assign rs_o      = rs_q;
   assign rt_o      = rt_q;
   assign next_pc_o = npc_q;

endmodule

// File: tb/tb_code2_pipe.sv
// Scoreboard bench for code2_pipe: directed vectors push expected outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_code2_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        we3;
   logic [15:0] next_pc_i;
   logic [23:0] instr_i;
   logic [4:0]  wa3;
   logic [31:0] wd3;
   logic        op_o;
   logic [2:0]  funct3_o;
   logic [4:0]  rd_o;
   logic [31:0] rs_o;
   logic [31:0] rt_o;
   logic [15:0] next_pc_o;

   code2_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .we3       (we3),
      .next_pc_i (next_pc_i),
      .instr_i   (instr_i),
      .wa3       (wa3),
      .wd3       (wd3),
      .op_o      (op_o),
      .funct3_o  (funct3_o),
      .rd_o      (rd_o),
      .rs_o      (rs_o),
      .rt_o      (rt_o),
      .next_pc_o (next_pc_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [15:0] pc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic cmp(input string tag, input string fld,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s got 0x%08h expected 0x%08h", tag, fld, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            cmp(e.tag, "op",     {31'd0, op_o},     {31'd0, e.op});
            cmp(e.tag, "funct3", {29'd0, funct3_o}, {29'd0, e.f3});
            cmp(e.tag, "rd",     {27'd0, rd_o},     {27'd0, e.rd});
            cmp(e.tag, "rs",     rs_o,              e.rs);
            cmp(e.tag, "rt",     rt_o,              e.rt);
            cmp(e.tag, "pc",     {16'd0, next_pc_o}, {16'd0, e.pc});
         end
      end
   end

   task automatic step(input string tag, input logic r, input logic we,
                       input logic [4:0] a, input logic [31:0] d,
                       input logic [15:0] pc, input logic [23:0] ins,
                       input logic eop, input logic [2:0] ef3, input logic [4:0] erd,
                       input logic [31:0] ers, input logic [31:0] ert,
                       input logic [15:0] epc);
      exp_t e;
      @(negedge clk);
      rst = r; we3 = we; wa3 = a; wd3 = d; next_pc_i = pc; instr_i = ins;
      e.tag = tag; e.op = eop; e.f3 = ef3; e.rd = erd;
      e.rs = ers; e.rt = ert; e.pc = epc;
      q.push_back(e);
   endtask

   initial begin
      rst = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; next_pc_i = '0; instr_i = '0;
      for (int i = 0; i < 5; i++)
         step("reset", 0, 1, 5'd7, 32'h11111111, 16'd99, 24'd3673,
              0, 0, 0, 32'h0, 32'h0, 16'd0);
      // rs=7, rt=31 both still zero: write during reset was dropped
      step("post_reset", 1, 0, 0, 0, 16'd0, 24'd511488,
           0, 0, 0, 32'h0, 32'h0, 16'd0);
      step("decode", 1, 0, 0, 0, 16'd42, 24'd3673,
           1, 3'd4, 5'd5, 32'h0, 32'h0, 16'd42);
      step("write7", 1, 1, 5'd7, 32'hDEADBEEF, 16'd1, 24'd0,
           0, 0, 0, 32'h0, 32'h0, 16'd1);
      step("read7_rs", 1, 0, 0, 0, 16'd2, 24'd3673,
           1, 3'd4, 5'd5, 32'hDEADBEEF, 32'h0, 16'd2);
      step("read7_rt", 1, 0, 0, 0, 16'd3, 24'd114688,
           0, 0, 0, 32'h0, 32'hDEADBEEF, 16'd3);
      step("bypass_rs", 1, 1, 5'd7, 32'h12345678, 16'd4, 24'd3673,
           1, 3'd4, 5'd5, 32'h12345678, 32'h0, 16'd4);
      step("hold7", 1, 0, 0, 0, 16'd5, 24'd118272,
           0, 0, 0, 32'h12345678, 32'h12345678, 16'd5);
      step("write0", 1, 1, 5'd0, 32'hFFFFFFFF, 16'd6, 24'd0,
           0, 0, 0, 32'h0, 32'h0, 16'd6);
      step("read0", 1, 0, 0, 0, 16'd7, 24'd0,
           0, 0, 0, 32'h0, 32'h0, 16'd7);
      step("reserved", 1, 0, 0, 0, 16'd8, 24'd16256601,
           1, 3'd4, 5'd5, 32'h12345678, 32'h0, 16'd8);
      step("write31", 1, 1, 5'd31, 32'hCAFEF00D, 16'd9, 24'd0,
           0, 0, 0, 32'h0, 32'h0, 16'd9);
      step("read31", 1, 0, 0, 0, 16'd10, 24'd511488,
           0, 0, 0, 32'h12345678, 32'hCAFEF00D, 16'd10);
      step("write7_a5", 1, 1, 5'd7, 32'hA5A5A5A5, 16'd11, 24'd0,
           0, 0, 0, 32'h0, 32'h0, 16'd11);
      step("mid_reset", 0, 0, 0, 0, 16'd12, 24'd3673,
           0, 0, 0, 32'h0, 32'h0, 16'd0);
      step("after_mid", 1, 0, 0, 0, 16'd13, 24'd511488,
           0, 0, 0, 32'h0, 32'h0, 16'd13);
      step("bypass_rt", 1, 1, 5'd31, 32'h0BADF00D, 16'd14, 24'd511488,
           0, 0, 0, 32'h0, 32'h0BADF00D, 16'd14);
      step("hold31", 1, 0, 0, 0, 16'd15, 24'd511488,
           0, 0, 0, 32'h0, 32'h0BADF00D, 16'd15);
      @(posedge clk);
      #3;
      cmp("drain", "queue", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
